// File: rtl/ram_pkg.sv
// Shared definitions for the clearable dual-port RAM.
// Contents: clear-sequencer state encoding, and the byte-enable merge helper
// used by both the array write path and the write-first read bypass.
package ram_pkg;

  // State encoding of the clear sequencer.
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_IDLE  = 1'b1;

  typedef enum logic {
    SEQ_CLEAR = ST_CLEAR,
    SEQ_IDLE  = ST_IDLE
  } seq_state_e;

  // be_merge operates on a fixed maximum width so that one function serves
  // every instance; callers zero-extend their operands and truncate the result.
  localparam int MAX_WIDTH = 512;
  localparam int MAX_BE    = MAX_WIDTH / 8;

  // Returns old_word with byte k replaced by new_word's byte k where be[k] = 1.
  function automatic logic [MAX_WIDTH-1:0] be_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BE-1:0]    be
  );
    logic [MAX_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < MAX_BE; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps addresses 0..DEPTH-1 once after reset or on clr.
// Ports: clk, rst (sync, active-high), clr (start/restart request);
//        busy (sweep running), clr_addr / clr_we (array write strobe for the sweep).
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  output logic                 busy,
  output logic [DEPTH_LOG-1:0] clr_addr,
  output logic                 clr_we
);

  localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

  seq_state_e           state;
  logic [DEPTH_LOG-1:0] cnt;

  // rst beats clr; clr restarts the sweep from address 0 in either state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_CLEAR;
      cnt   <= '0;
    end else if (clr) begin
      state <= SEQ_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        SEQ_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            // Last word written on this edge; park the counter at 0 so a
            // non-power-of-two depth never leaves it pointing past the array.
            state <= SEQ_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DEPTH_LOG'(1);
          end
        end
        default: begin
          state <= SEQ_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Every CLEAR cycle writes one word, so busy and the write strobe coincide.
  assign busy     = (state == SEQ_CLEAR);
  assign clr_we   = (state == SEQ_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (1W/1R, one clock) with byte enables, selectable
// async/registered read, read-during-write policy and a hardware clear sweep.
// Ports: clk, rst; clr/busy (clear control); we/be/addr_wr/data_wr/wr_err
//        (write port); re/addr_rd/data_rd/rd_valid (read port).
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 16,
  parameter int               DEPTH_LOG   = $clog2(DEPTH),
  parameter int               BE_WIDTH    = WIDTH / 8,
  parameter int               READ_REG    = 1,
  parameter int               WRITE_FIRST = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  output logic                 busy,
  input  logic                 we,
  input  logic [BE_WIDTH-1:0]  be,
  input  logic [DEPTH_LOG-1:0] addr_wr,
  input  logic [WIDTH-1:0]     data_wr,
  output logic                 wr_err,
  input  logic                 re,
  input  logic [DEPTH_LOG-1:0] addr_rd,
  output logic [WIDTH-1:0]     data_rd,
  output logic                 rd_valid
);

  logic [WIDTH-1:0]     mem [DEPTH];

  logic [DEPTH_LOG-1:0] clr_addr;
  logic                 clr_we;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 wr_ok;
  logic [WIDTH-1:0]     wr_word;
  logic [WIDTH-1:0]     rd_word;

  ram_clr_seq #(
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // With a power-of-two depth every address is legal, so the range checks
  // collapse to constants instead of a compare.
  generate
    if (DEPTH == (1 << DEPTH_LOG)) begin : g_pow2
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [DEPTH_LOG:0] DEPTH_EXT = (DEPTH_LOG + 1)'(DEPTH);
      assign wr_in_range = ({1'b0, addr_wr} < DEPTH_EXT);
      assign rd_in_range = ({1'b0, addr_rd} < DEPTH_EXT);
    end
  endgenerate

  assign wr_ok = we & ~busy & wr_in_range;

  // Merged word: new bytes where be is set, current contents elsewhere. Also
  // serves as the write-first bypass value, since on a collision the read
  // and write address are the same word.
  assign wr_word = WIDTH'(be_merge(MAX_WIDTH'(mem[addr_wr]),
                                   MAX_WIDTH'(data_wr),
                                   MAX_BE'(be)));

  // Out-of-range read addresses never index the array.
  assign rd_word = rd_in_range ? mem[addr_rd] : CLEAR_VALUE;

  // Array: the sweep and user writes are mutually exclusive (user writes need
  // ~busy). Nothing is written on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_addr] <= CLEAR_VALUE;
      end else if (wr_ok) begin
        mem[addr_wr] <= wr_word;
      end
    end
  end

  // Dropped-write flag, visible the cycle after the offending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= we & (busy | ~wr_in_range);
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [WIDTH-1:0] rd_q;
      logic             rd_vld_q;
      logic             collide;
      logic [WIDTH-1:0] rd_next;

      assign collide = wr_ok & (addr_wr == addr_rd);

      always_comb begin
        rd_next = rd_word;
        if ((WRITE_FIRST != 0) && collide) begin
          rd_next = wr_word;
        end
      end

      // data_rd holds unless a read is accepted; an out-of-range read loads
      // CLEAR_VALUE but is not flagged valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q     <= '0;
          rd_vld_q <= 1'b0;
        end else if (re && !busy) begin
          if (rd_in_range) begin
            rd_q     <= rd_next;
            rd_vld_q <= 1'b1;
          end else begin
            rd_q     <= CLEAR_VALUE;
            rd_vld_q <= 1'b0;
          end
        end else begin
          rd_vld_q <= 1'b0;
        end
      end

      assign data_rd  = rd_q;
      assign rd_valid = rd_vld_q;
    end else begin : g_rd_async
      assign data_rd  = rd_word;
      assign rd_valid = re & ~busy & rd_in_range;
    end
  endgenerate

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised simple dual-port RAM (one write port, one read port, single clock): the next generation of the team's dual-port RAM.
- Adds byte-enable writes.
- Read latency selectable: asynchronous or registered.
- Programmable read-during-write collision policy.
- Hardware clear sequencer that sweeps every word to a constant after reset or on request.
Used as the storage macro under FIFOs and register files in the verification-journey designs.

Parameters:
WIDTH, 16, data word width in bits; must be a multiple of 8.
DEPTH, 16, number of words; need not be a power of two.
DEPTH_LOG, $clog2(DEPTH), address width.
BE_WIDTH, WIDTH/8, number of byte enables.
READ_REG, 1, 0 = asynchronous read; 1 = registered read, latency 1.
WRITE_FIRST, 1, collision policy for registered read: 1 = new data, 0 = old data.
CLEAR_VALUE, 0, word written to every address by the clear sweep.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
clr  input  1  one-cycle request to start a clear sweep.
busy  output  1  high while the clear sweep runs.
we  input  1  write request, active-high.
be  input  BE_WIDTH  byte enables; bit k covers data_wr[8k+7:8k].
addr_wr  input  DEPTH_LOG  write address.
data_wr  input  WIDTH  write data.
wr_err  output  1  one-cycle pulse: write dropped (busy, or addr_wr >= DEPTH).
re  input  1  read request.
addr_rd  input  DEPTH_LOG  read address.
data_rd  output  WIDTH  read data.
rd_valid  output  1  data_rd is valid for an accepted read.

Behaviour:
- FSM states: CLEAR and IDLE. busy = (state == CLEAR).
- Reset: while rst is high at an edge:
  - state <= CLEAR, clear counter <= 0.
  - data_rd register <= 0, rd_valid <= 0, wr_err <= 0.
  - No array write during the reset cycle. Reset mid-sweep restarts the sweep at address 0.
- CLEAR: each edge writes mem[cnt] = CLEAR_VALUE (all bytes) and increments cnt. At cnt == DEPTH-1, state <= IDLE.
  - busy is high for exactly DEPTH cycles after rst deasserts.
- clr in IDLE: state <= CLEAR, cnt <= 0. clr in CLEAR restarts cnt at 0. rst has priority over clr.
- Write, accepted when we & ~busy & (addr_wr < DEPTH):
  - Byte k of mem[addr_wr] is updated only where be[k] = 1.
  - be = 0 is accepted but leaves memory unchanged.
- Write, rejected when we & (busy | addr_wr >= DEPTH):
  - Memory is untouched.
  - wr_err is registered, so it is high in the cycle after the rejected request.
- Read, READ_REG = 0:
  - data_rd = mem[addr_rd] combinationally.
  - rd_valid = re & ~busy & (addr_rd < DEPTH), combinational.
  - A write to the same address becomes visible after the edge.
- Read, READ_REG = 1:
  - On an edge with re & ~busy, data_rd <= mem[addr_rd] and rd_valid <= 1. Otherwise rd_valid <= 0 and data_rd holds.
  - Out-of-range address: data_rd <= CLEAR_VALUE, rd_valid <= 0.
- Collision (READ_REG = 1, accepted read and accepted write to the same address on the same edge):
  - WRITE_FIRST = 1: returned bytes where be[k] = 1 are taken from data_wr; the remaining bytes are the old contents.
  - WRITE_FIRST = 0: returns the full old word.
- Reads during CLEAR: never valid. data_rd holds its value in registered mode.
- Widths: counter is DEPTH_LOG bits. For DEPTH = 2^DEPTH_LOG, the address check is constant-true.

Decomposition:
- Shared package ram_pkg holds:
  - localparams for state encoding: ST_CLEAR, ST_IDLE.
  - function be_merge(old, new, be), used by the write path and the collision bypass.
- One sub-module, ram_clr_seq: FSM plus counter, outputs busy / clr_addr / clr_we.
- Array and read path stay in the top level.

Test Plan:
- Reset sweep, defaults (WIDTH=16, DEPTH=16, CLEAR_VALUE=16'hDEAD): release rst → busy high exactly 16 cycles. Then read all 16 addresses → each returns 16'hDEAD with rd_valid = 1.
- Byte enables: write 16'h1234 to addr 3 with be=2'b11, then 16'hAB00 with be=2'b10 → read addr 3 returns 16'hAB34.
- Collision, registered read: mem[5] = 16'h0000; same edge has write 16'hBEEF (be=2'b01) and read of addr 5:
  - WRITE_FIRST=1 → data_rd 16'h00EF next cycle.
  - WRITE_FIRST=0 → 16'h0000.
  - A following read returns 16'h00EF in both cases.
- Write during busy: assert clr, then we to addr 2 with 16'h5555 in cycle 3 of the sweep → wr_err pulses one cycle; after the sweep, addr 2 reads CLEAR_VALUE.
- Non-power-of-two (DEPTH=12) and async mode:
  - Write addr 13 → wr_err, no array change.
  - READ_REG=0: write 16'h00A5 to addr 7 → data_rd on addr 7 changes in the same cycle as the write edge, with no clock latency.
- Reset mid-sweep: assert rst at cnt=9 → busy stays high, and the sweep takes a full 16 cycles after release.
